rv_hazard_unit: RTL and testbench
=================================

// Module: rv_hazard_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage rv core. Successor to the
//  forwarding-only scheme: adds load-use stalls with configurable load latency, a data-memory
//  wait freeze, and branch-redirect flush. Sits beside the pipeline registers and drives their
//  stall/flush enables plus the EX operand-forward selects.
// PARAMETERS
//  REG_AW      5   register index width (2**REG_AW architectural regs; x0 hardwired zero)
//  LOAD_LAT    1   cycles after MEM before load data is forwardable (1..7)
//  FLUSH_DEPTH 3   younger pipeline regs flushed on redirect (1..3: IF/ID, ID/EX, EX/MEM)
// PORTS
//  clk             in   1       core clock
//  rst             in   1       synchronous reset, active-high
//  id_rs1_i        in   REG_AW  rs1 of instr in ID
//  id_rs2_i        in   REG_AW  rs2 of instr in ID
//  id_use_rs1_i    in   1       ID instr reads rs1
//  id_use_rs2_i    in   1       ID instr reads rs2
//  ex_rs1_i        in   REG_AW  rs1 of instr in EX
//  ex_rs2_i        in   REG_AW  rs2 of instr in EX
//  ex_rd_i         in   REG_AW  rd of instr in EX
//  ex_reg_write_i  in   1       EX instr writes rd
//  ex_mem_read_i   in   1       EX instr is a load
//  mem_rd_i        in   REG_AW  rd of instr in MEM
//  mem_reg_write_i in   1       MEM instr writes rd
//  mem_mem_read_i  in   1       MEM instr is a load
//  wb_rd_i         in   REG_AW  rd of instr in WB
//  wb_reg_write_i  in   1       WB instr writes rd
//  dmem_ready_i    in   1       data memory access completes this cycle
//  redirect_i      in   1       branch taken in MEM; PC loads target
//  stall_front_o   out  1       hold PC and IF/ID
//  bubble_ex_o     out  1       load NOP into ID/EX
//  freeze_all_o    out  1       hold every pipeline register
//  flush_o         out  3       [0] IF/ID, [1] ID/EX, [2] EX/MEM clear to NOP
//  forward_a_o     out  2       EX op1 select
//  forward_b_o     out  2       EX op2/store-data select
//  stall_cnt_o     out  32      stall cycles (perf)
//  flush_cnt_o     out  32      redirect events (perf)
// BEHAVIOUR
//  - One clock clk; reset rst synchronous, active-high. In reset: state RUN, counter 0, all outputs 0.
//  - FSM states RUN, LD_STALL, MEM_WAIT; ld_cnt 3-bit down counter.
//  - Hazard hit: ex_mem_read_i & ex_reg_write_i & ex_rd_i!=0 & ((use_rs1 & rs1==rd)|(use_rs2 & rs2==rd)).
//  - RUN: hazard -> stall_front_o=1, bubble_ex_o=1 same cycle (combinational); if LOAD_LAT>1
//    enter LD_STALL with ld_cnt=LOAD_LAT-1, else remain RUN.
//  - LD_STALL: stall_front_o=1, bubble_ex_o=1; ld_cnt decrements; at ld_cnt==1 -> RUN next.
//    Total stall exactly LOAD_LAT cycles.
//  - MEM_WAIT entered from any state when mem_mem_read_i & !dmem_ready_i: freeze_all_o=1, all
//    other stall/bubble outputs 0, ld_cnt held; exit to previous state the cycle after
//    dmem_ready_i=1. Freeze has priority over load-use.
//  - redirect_i (ignored in MEM_WAIT): flush_o[i]=1 for i<FLUSH_DEPTH, same cycle; cancels any
//    load-use stall (stall_front_o, bubble_ex_o forced 0); state -> RUN, ld_cnt -> 0.
//  - Forwarding (comb, per operand, rs!=0 only): 2'b10 MEM if mem_reg_write_i & mem_rd==rs &
//    !mem_mem_read_i; else 2'b01 WB if wb_reg_write_i & wb_rd==rs; else 2'b00 regfile. MEM beats WB.
//  - Counters saturate at 2**32-1.
// CONFIGURATION
//  RV_HAZARD_PERF_EN defined: stall_cnt_o counts cycles with stall_front_o|freeze_all_o;
//  flush_cnt_o counts cycles with redirect_i accepted; both reset to 0.
//  Not defined: counters absent, stall_cnt_o/flush_cnt_o tied to 0.
// STRUCTURE
//  Shared package rv_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; FSM state encodings.
//  Sub-module rv_fwd_sel (one operand's select), instantiated twice for A and B.
// TESTING
//  - mem_rd=5 write, wb_rd=5 write, ex_rs1=5 -> forward_a_o=10; mem_rd=0 -> 01 from WB; x0 -> 00.
//  - LOAD_LAT=1: ex load rd=7, id_rs2=7 used -> stall_front_o=bubble_ex_o=1 exactly 1 cycle.
//  - LOAD_LAT=3: same stimulus -> 3 stall cycles, then RUN; rs use flag 0 -> no stall.
//  - mem load, dmem_ready_i low 4 cycles -> freeze_all_o=1 4 cycles, releases on ready.
//  - redirect_i in 2nd LD_STALL cycle -> flush_o=3'b111, stalls 0 same cycle, RUN next.
//  - RV_HAZARD_PERF_EN: above sequence -> stall_cnt_o and flush_cnt_o match counted events;
//    rst mid-stall -> RUN, counters 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the rv core hazard controller:
// forward-select codes and hazard FSM state encodings.
package rv_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LD_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

endpackage

// File: rtl/rv_fwd_sel.sv
// EX operand forward select for one source register.
// MEM result beats WB result; loads in MEM are not forwardable.
module rv_fwd_sel
  import rv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  output logic [1:0]        sel_o
);

  logic rs_nz;
  logic mem_hit;
  logic wb_hit;

  assign rs_nz   = (rs_i != '0);
  assign mem_hit = rs_nz & mem_reg_write_i
                 & !mem_mem_read_i
                 & (mem_rd_i == rs_i);
  assign wb_hit  = rs_nz & wb_reg_write_i
                 & (wb_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_RF;
    unique case (1'b1)
      mem_hit:           sel_o = FWD_MEM;
      wb_hit & !mem_hit: sel_o = FWD_WB;
      default:           sel_o = FWD_RF;
    endcase
  end

endmodule

// File: rtl/rv_hazard_unit.sv
// Load-use stall, dmem freeze, redirect flush and operand forwarding.
// Perf counters present only when RV_HAZARD_PERF_EN is defined.
module rv_hazard_unit
  import rv_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic              dmem_ready_i,
  input  logic              redirect_i,
  output logic              stall_front_o,
  output logic              bubble_ex_o,
  output logic              freeze_all_o,
  output logic [2:0]        flush_o,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_MASK =
    3'((1 << FLUSH_DEPTH) - 1);

  hz_state_e  state_q, state_d;
  hz_state_e  prev_q, prev_d;
  logic [2:0] ld_cnt_q, ld_cnt_d;

  logic       hazard;
  logic       in_wait;
  logic       freeze;
  logic       stall;
  logic       redir_ok;
  logic [2:0] flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign hazard = ex_mem_read_i & ex_reg_write_i
                & (ex_rd_i != '0)
                & ((id_use_rs1_i & (id_rs1_i == ex_rd_i))
                 | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  assign in_wait = (state_q == ST_MEM_WAIT);
  // Stay frozen until ready; the ready cycle itself is not frozen.
  assign freeze  = !dmem_ready_i
                 & (in_wait | mem_mem_read_i);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    ld_cnt_d = ld_cnt_q;
    stall    = 1'b0;
    flush    = 3'b000;
    redir_ok = 1'b0;
    if (freeze) begin
      if (!in_wait) begin
        prev_d  = state_q;
        state_d = ST_MEM_WAIT;
      end
    end else if (in_wait) begin
      state_d = prev_q;
    end else if (redirect_i) begin
      redir_ok = 1'b1;
      flush    = FLUSH_MASK;
      state_d  = ST_RUN;
      ld_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = ST_LD_STALL;
              ld_cnt_d = LD_INIT;
            end
          end
        end
        ST_LD_STALL: begin
          stall    = 1'b1;
          ld_cnt_d = ld_cnt_q - 3'd1;
          if (ld_cnt_q == 3'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      prev_q   <= ST_RUN;
      ld_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  rv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i            (ex_rs1_i),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_mem_read_i  (mem_mem_read_i),
    .wb_rd_i         (wb_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .sel_o           (fwd_a)
  );

  rv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i            (ex_rs2_i),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_mem_read_i  (mem_mem_read_i),
    .wb_rd_i         (wb_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .sel_o           (fwd_b)
  );

  assign stall_front_o = stall & !rst;
  assign bubble_ex_o   = stall & !rst;
  assign freeze_all_o  = freeze & !rst;
  assign flush_o       = flush & {3{!rst}};
  assign forward_a_o   = fwd_a & {2{!rst}};
  assign forward_b_o   = fwd_b & {2{!rst}};

`ifdef RV_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall | freeze) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_ok && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q & {32{!rst}};
  assign flush_cnt_o = flush_cnt_q & {32{!rst}};
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Scoreboard bench for rv_hazard_unit: three parameterisations
// driven in lockstep, checked against a remaining-stall-count model.
module tb_rv_hazard_unit;

  typedef struct {
    logic       rst;
    logic [4:0] id_rs1, id_rs2;
    logic       u1, u2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_we, ex_ld;
    logic [4:0] mem_rd;
    logic       mem_we, mem_ld;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic       rdy, redir;
  } in_t;

  typedef struct {
    int          k;
    int          cyc;
    logic        stall, bubble, freeze;
    logic [2:0]  flush;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 7;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
  logic [4:0] mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_reg_write;
  logic       ex_mem_read, mem_reg_write, mem_mem_read;
  logic       wb_reg_write, dmem_ready, redirect;

  logic [2:0]  o_stall, o_bubble, o_freeze;
  logic [2:0]  o_flush [3];
  logic [1:0]  o_fa [3];
  logic [1:0]  o_fb [3];
  logic [31:0] o_sc [3];
  logic [31:0] o_fc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv_hazard_unit #(
      .REG_AW      (5),
      .LOAD_LAT    (lat_of(g)),
      .FLUSH_DEPTH (dep_of(g))
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1_i        (id_rs1),
      .id_rs2_i        (id_rs2),
      .id_use_rs1_i    (id_use_rs1),
      .id_use_rs2_i    (id_use_rs2),
      .ex_rs1_i        (ex_rs1),
      .ex_rs2_i        (ex_rs2),
      .ex_rd_i         (ex_rd),
      .ex_reg_write_i  (ex_reg_write),
      .ex_mem_read_i   (ex_mem_read),
      .mem_rd_i        (mem_rd),
      .mem_reg_write_i (mem_reg_write),
      .mem_mem_read_i  (mem_mem_read),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_reg_write),
      .dmem_ready_i    (dmem_ready),
      .redirect_i      (redirect),
      .stall_front_o   (o_stall[g]),
      .bubble_ex_o     (o_bubble[g]),
      .freeze_all_o    (o_freeze[g]),
      .flush_o         (o_flush[g]),
      .forward_a_o     (o_fa[g]),
      .forward_b_o     (o_fb[g]),
      .stall_cnt_o     (o_sc[g]),
      .flush_cnt_o     (o_fc[g])
    );
  end

  // Model state: stall cycles still owed, waiting on dmem, counters.
  int      sl [3];
  bit      wt [3];
  longint  sc [3];
  longint  fc [3];
  exp_t    sb [$];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;

  function automatic logic [1:0] fwd(input logic [4:0] rs,
                                     input in_t s);
    if (rs == 0) return 2'b00;
    if (s.mem_we && !s.mem_ld && s.mem_rd == rs) return 2'b10;
    if (s.wb_we && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model(input int k, input in_t s,
                       output exp_t e);
    bit hz, fz;
    e = '{k: k, cyc: cyc, stall: 0, bubble: 0, freeze: 0,
          flush: 0, fa: 0, fb: 0, sc: 0, fc: 0};
    if (s.rst) begin
      sl[k] = 0; wt[k] = 0; sc[k] = 0; fc[k] = 0;
      return;
    end
`ifdef RV_HAZARD_PERF_EN
    e.sc = 32'(sc[k]);
    e.fc = 32'(fc[k]);
`endif
    e.fa = fwd(s.ex_rs1, s);
    e.fb = fwd(s.ex_rs2, s);
    hz = s.ex_ld && s.ex_we && s.ex_rd != 0 &&
         ((s.u1 && s.id_rs1 == s.ex_rd) ||
          (s.u2 && s.id_rs2 == s.ex_rd));
    fz = !s.rdy && (wt[k] || s.mem_ld);
    if (fz) begin
      e.freeze = 1; wt[k] = 1;
    end else if (wt[k]) begin
      wt[k] = 0;
    end else if (s.redir) begin
      e.flush = 3'((1 << dep_of(k)) - 1);
      sl[k] = 0;
      if (fc[k] < 64'hFFFF_FFFF) fc[k]++;
    end else if (sl[k] > 0) begin
      e.stall = 1; e.bubble = 1; sl[k]--;
    end else if (hz) begin
      e.stall = 1; e.bubble = 1; sl[k] = lat_of(k) - 1;
    end
    if ((e.stall || e.freeze) && sc[k] < 64'hFFFF_FFFF) sc[k]++;
  endtask

  task automatic drive(input in_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    ex_reg_write = s.ex_we; ex_mem_read = s.ex_ld;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_we;
    mem_mem_read = s.mem_ld;
    wb_rd = s.wb_rd; wb_reg_write = s.wb_we;
    dmem_ready = s.rdy; redirect = s.redir;
    for (int k = 0; k < 3; k++) begin
      model(k, s, e);
      sb.push_back(e);
    end
    cyc++;
  endtask

  function automatic in_t idle();
    in_t s;
    s = '{rst: 0, id_rs1: 0, id_rs2: 0, u1: 0, u2: 0,
          ex_rs1: 0, ex_rs2: 0, ex_rd: 0, ex_we: 0, ex_ld: 0,
          mem_rd: 0, mem_we: 0, mem_ld: 0, wb_rd: 0, wb_we: 0,
          rdy: 1, redir: 0};
    return s;
  endfunction

  function automatic in_t ld_use();
    in_t s;
    s = idle();
    s.ex_ld = 1; s.ex_we = 1; s.ex_rd = 7;
    s.id_rs2 = 7; s.u2 = 1;
    return s;
  endfunction

  task automatic chk(input string nm, input exp_t e,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc%0d got=%0h want=%0h",
               nm, e.k, e.cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", e, 32'(o_stall[e.k]), 32'(e.stall));
        chk("bubble", e, 32'(o_bubble[e.k]), 32'(e.bubble));
        chk("freeze", e, 32'(o_freeze[e.k]), 32'(e.freeze));
        chk("flush", e, 32'(o_flush[e.k]), 32'(e.flush));
        chk("fwd_a", e, 32'(o_fa[e.k]), 32'(e.fa));
        chk("fwd_b", e, 32'(o_fb[e.k]), 32'(e.fb));
        chk("stall_cnt", e, o_sc[e.k], e.sc);
        chk("flush_cnt", e, o_fc[e.k], e.fc);
      end
    end
  end

  initial begin : stim
    in_t s;
    s = idle();
    s.rst = 1;
    rst = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0;
    id_use_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_rd = 0;
    mem_reg_write = 0; mem_mem_read = 0; wb_rd = 0;
    wb_reg_write = 0; dmem_ready = 1; redirect = 0;
    for (int k = 0; k < 3; k++) begin
      sl[k] = 0; wt[k] = 0; sc[k] = 0; fc[k] = 0;
    end
    repeat (2) drive(s);

    // forwarding: MEM beats WB, then WB, then x0
    s = idle();
    s.mem_rd = 5; s.mem_we = 1; s.wb_rd = 5; s.wb_we = 1;
    s.ex_rs1 = 5; s.ex_rs2 = 5;
    drive(s);
    s.mem_rd = 0;
    drive(s);
    s.ex_rs1 = 0; s.ex_rs2 = 0;
    drive(s);

    // load-use, then bubble in EX
    drive(ld_use());
    repeat (8) drive(idle());
    s = ld_use(); s.u2 = 0;
    drive(s);
    drive(idle());

    // dmem wait: ready low for four cycles
    s = idle(); s.mem_ld = 1; s.mem_we = 1; s.mem_rd = 9;
    s.rdy = 0;
    repeat (4) drive(s);
    s.rdy = 1;
    drive(s);
    repeat (2) drive(idle());

    // redirect in second LD_STALL cycle
    drive(ld_use());
    drive(idle());
    s = idle(); s.redir = 1;
    drive(s);
    repeat (3) drive(idle());

    // freeze during load-use stall
    drive(ld_use());
    s = idle(); s.mem_ld = 1; s.rdy = 0;
    repeat (2) drive(s);
    s.rdy = 1;
    drive(s);
    repeat (8) drive(idle());

    // reset mid-stall
    drive(ld_use());
    s = idle(); s.rst = 1;
    drive(s);
    repeat (3) drive(idle());

    for (int i = 0; i < 3000; i++) begin
      s.rst    = ($urandom_range(0, 199) == 0);
      s.id_rs1 = 5'($urandom_range(0, 7));
      s.id_rs2 = 5'($urandom_range(0, 7));
      s.u1     = 1'($urandom);
      s.u2     = 1'($urandom);
      s.ex_rs1 = 5'($urandom_range(0, 7));
      s.ex_rs2 = 5'($urandom_range(0, 7));
      s.ex_rd  = 5'($urandom_range(0, 7));
      s.ex_we  = ($urandom_range(0, 4) != 0);
      s.ex_ld  = ($urandom_range(0, 4) < 2);
      s.mem_rd = 5'($urandom_range(0, 7));
      s.mem_we = 1'($urandom);
      s.mem_ld = ($urandom_range(0, 9) < 3);
      s.wb_rd  = 5'($urandom_range(0, 7));
      s.wb_we  = 1'($urandom);
      s.rdy    = ($urandom_range(0, 3) != 0);
      s.redir  = ($urandom_range(0, 11) == 0);
      if (!s.rdy && s.mem_ld) s.redir = 0;
      drive(s);
    end

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
